// File: rtl/dm_store_buffer_pkg.sv
// ---------------------------------------------------------------------------
// dm_store_buffer_pkg
//   Shared constants and helpers for the data-memory posted-write buffer.
//   SB_DEPTH : default number of store entries (power of two, >= 2)
//   SB_AW    : default byte-address width
//   ring_op_e / ring_op() : encodes the per-cycle push/pop combination
//                           used to update the occupancy counter.
// ---------------------------------------------------------------------------
package dm_store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;

    typedef enum logic [1:0] {
        RING_IDLE = 2'b00,
        RING_POP  = 2'b01,
        RING_PUSH = 2'b10,
        RING_BOTH = 2'b11
    } ring_op_e;

    function automatic ring_op_e ring_op(input logic push, input logic pop);
        return ring_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/dm_store_buffer_sb_ring.sv
// ---------------------------------------------------------------------------
// sb_ring
//   Ring storage for the store buffer: DEPTH entries of {word addr, byteen,
//   wdata, valid}, read/write pointers and the occupancy count.
//   Ports:
//     clk, reset              : clock, asynchronous active-high reset
//     push, push_*            : write one entry at the write pointer
//     pop                     : retire the head entry (caller guarantees !empty)
//     head_addr/byteen/wdata  : fields of the entry at the read pointer
//     valid_vec, addr_vec     : all valid bits and word addresses (hazard compare)
//     count                   : number of pending entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sb_ring
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1,
    localparam int WW   = AW - 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [WW-1:0]       push_addr,
    input  logic [3:0]          push_byteen,
    input  logic [31:0]         push_wdata,
    input  logic                pop,
    output logic [WW-1:0]       head_addr,
    output logic [3:0]          head_byteen,
    output logic [31:0]         head_wdata,
    output logic [DEPTH-1:0]    valid_vec,
    output logic [DEPTH*WW-1:0] addr_vec,
    output logic [CW-1:0]       count
);

    logic [WW-1:0]    addr_r   [DEPTH];
    logic [3:0]       byteen_r [DEPTH];
    logic [31:0]      wdata_r  [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    // Entry storage, pointers, valid bits and occupancy count.
    // Pointers are PW bits wide so they wrap on their own (DEPTH is 2^PW).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i]   <= '0;
                byteen_r[i] <= 4'b0000;
                wdata_r[i]  <= 32'h0000_0000;
            end
        end else begin
            if (push) begin
                addr_r[wr_ptr_r]   <= push_addr;
                byteen_r[wr_ptr_r] <= push_byteen;
                wdata_r[wr_ptr_r]  <= push_wdata;
                valid_r[wr_ptr_r]  <= 1'b1;
                wr_ptr_r           <= wr_ptr_r + PW'(1);
            end
            // push never targets the head slot while pop is active: a push
            // needs a free slot, a pop needs a non-empty ring.
            if (pop) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PW'(1);
            end
            case (ring_op(push, pop))
                RING_PUSH: count_r <= count_r + CW'(1);
                RING_POP:  count_r <= count_r - CW'(1);
                RING_IDLE: count_r <= count_r;
                RING_BOTH: count_r <= count_r;
                default:   count_r <= count_r;
            endcase
        end
    end

    assign head_addr   = addr_r[rd_ptr_r];
    assign head_byteen = byteen_r[rd_ptr_r];
    assign head_wdata  = wdata_r[rd_ptr_r];
    assign valid_vec   = valid_r;
    assign count       = count_r;

    // Flatten the per-entry word addresses for the hazard comparator.
    always_comb begin
        addr_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            addr_vec[i*WW +: WW] = addr_r[i];
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// ---------------------------------------------------------------------------
// dm_store_buffer
//   Posted-write buffer between the M-stage data-memory bridge and the
//   external data-memory port. Stores are queued in order and drained
//   through a req/ack handshake; loads to a word with a pending store stall.
//   Ports:
//     clk, reset                     : clock, asynchronous active-high reset
//     st_valid/addr/byteen/wdata     : store from bridge (byteen==0 ignored)
//     st_ready                       : buffer has a free entry
//     ld_valid, ld_addr              : M-stage load
//     ld_stall                       : load word matches a pending store
//     mem_req/addr/byteen/wdata      : head entry presented to memory
//     mem_ack                        : memory accepted the head entry
//     empty, count                   : occupancy status
// ---------------------------------------------------------------------------
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    localparam int CW   = $clog2(DEPTH) + 1,
    localparam int WW   = AW - 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [3:0]    st_byteen,
    input  logic [31:0]   st_wdata,
    output logic          st_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_stall,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_byteen,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic                push_s;
    logic                pop_s;
    logic [WW-1:0]       head_addr_s;
    logic [DEPTH-1:0]    valid_vec_s;
    logic [DEPTH*WW-1:0] addr_vec_s;
    logic                hit_s;
    logic                unused_addr_bits_s;

    // Ready depends on occupancy only, so a full buffer never takes a store
    // in the same cycle the head is acked.
    assign st_ready = (count != CW'(DEPTH));
    assign empty    = (count == CW'(0));
    assign mem_req  = !empty;
    assign push_s   = st_valid && (st_byteen != 4'b0000) && st_ready;
    assign pop_s    = mem_req && mem_ack;

    sb_ring #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ring (
        .clk         (clk),
        .reset       (reset),
        .push        (push_s),
        .push_addr   (st_addr[AW-1:2]),
        .push_byteen (st_byteen),
        .push_wdata  (st_wdata),
        .pop         (pop_s),
        .head_addr   (head_addr_s),
        .head_byteen (mem_byteen),
        .head_wdata  (mem_wdata),
        .valid_vec   (valid_vec_s),
        .addr_vec    (addr_vec_s),
        .count       (count)
    );

    assign mem_addr = {head_addr_s, 2'b00};

    // Word-granular match of the load against every pending entry; the
    // entry being acked this cycle is still valid and therefore still hits.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_vec_s[i] && (addr_vec_s[i*WW +: WW] == ld_addr[AW-1:2])) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign ld_stall = ld_valid && hit_s;

    // Byte offsets are irrelevant at word granularity.
    assign unused_addr_bits_s = ^{st_addr[1:0], ld_addr[1:0]};

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [3:0]  st_byteen;
    logic [31:0] st_wdata;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        empty;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [3:0]  sb;
        logic [31:0] sd;
        logic        lv;
        logic [31:0] la;
        logic        ack;
        logic        e_ready;
        logic        e_stall;
        logic        e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [2:0]  e_count;
    } vec_t;

    vec_t vq[$];

    dm_store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_byteen  (st_byteen),
        .st_wdata   (st_wdata),
        .st_ready   (st_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_stall   (ld_stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_byteen (mem_byteen),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .empty      (empty),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic sv, input logic [31:0] sa, input logic [3:0] sb,
                       input logic [31:0] sd, input logic lv, input logic [31:0] la,
                       input logic ack, input logic er, input logic es, input logic eq,
                       input logic [31:0] ea, input logic [3:0] eb, input logic [31:0] ed,
                       input logic [2:0] ec);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sb = sb; v.sd = sd;
        v.lv = lv; v.la = la; v.ack = ack;
        v.e_ready = er; v.e_stall = es; v.e_req = eq;
        v.e_addr = ea; v.e_be = eb; v.e_wdata = ed; v.e_count = ec;
        vq.push_back(v);
    endtask

    task automatic drive_idle();
        st_valid  = 1'b0;
        st_addr   = 32'h0;
        st_byteen = 4'h0;
        st_wdata  = 32'h0;
        ld_valid  = 1'b0;
        ld_addr   = 32'h0;
        mem_ack   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        ld_valid = 1'b1;
        #1;
        chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
        chk("rst_st_ready", {31'h0, st_ready}, 32'd1);
        chk("rst_empty", {31'h0, empty}, 32'd1);
        chk("rst_count", {29'h0, count}, 32'd0);
        chk("rst_ld_stall", {31'h0, ld_stall}, 32'd0);
        ld_valid = 1'b0;
        reset = 1'b0;

        // ------- vector table: sv sa sb sd | lv la ack | ready stall req addr be wdata count
        // single store, stable while waiting for ack
        add(1, 32'h10, 4'hF, 32'h1234_5678, 0, 0, 0,  1, 0, 0, 32'h0,  4'h0, 32'h0, 0);
        add(0, 0, 0, 0, 0, 0, 0,                      1, 0, 1, 32'h10, 4'hF, 32'h1234_5678, 1);
        add(0, 0, 0, 0, 0, 0, 0,                      1, 0, 1, 32'h10, 4'hF, 32'h1234_5678, 1);
        add(0, 0, 0, 0, 0, 0, 1,                      1, 0, 1, 32'h10, 4'hF, 32'h1234_5678, 1);
        add(0, 0, 0, 0, 0, 0, 0,                      1, 0, 0, 32'h0,  4'h0, 32'h0, 0);
        // fill to 4, then drain in order
        add(1, 32'h00, 4'hF, 32'hA0, 0, 0, 0,         1, 0, 0, 32'h0,  4'h0, 32'h0,  0);
        add(1, 32'h04, 4'hF, 32'hA1, 0, 0, 0,         1, 0, 1, 32'h00, 4'hF, 32'hA0, 1);
        add(1, 32'h08, 4'hF, 32'hA2, 0, 0, 0,         1, 0, 1, 32'h00, 4'hF, 32'hA0, 2);
        add(1, 32'h0C, 4'hF, 32'hA3, 0, 0, 0,         1, 0, 1, 32'h00, 4'hF, 32'hA0, 3);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 1, 32'h00, 4'hF, 32'hA0, 4);
        add(0, 0, 0, 0, 0, 0, 1,                      0, 0, 1, 32'h00, 4'hF, 32'hA0, 4);
        add(0, 0, 0, 0, 0, 0, 1,                      1, 0, 1, 32'h04, 4'hF, 32'hA1, 3);
        add(0, 0, 0, 0, 0, 0, 1,                      1, 0, 1, 32'h08, 4'hF, 32'hA2, 2);
        add(0, 0, 0, 0, 0, 0, 1,                      1, 0, 1, 32'h0C, 4'hF, 32'hA3, 1);
        add(0, 0, 0, 0, 0, 0, 0,                      1, 0, 0, 32'h0,  4'h0, 32'h0,  0);
        // byteen==0 store ignored, ack while empty ignored
        add(1, 32'h20, 4'h0, 32'hFF, 0, 0, 0,         1, 0, 0, 32'h0,  4'h0, 32'h0,  0);
        add(0, 0, 0, 0, 0, 0, 1,                      1, 0, 0, 32'h0,  4'h0, 32'h0,  0);
        add(0, 0, 0, 0, 0, 0, 0,                      1, 0, 0, 32'h0,  4'h0, 32'h0,  0);
        // load hazard on a byte store to 0x13
        add(1, 32'h13, 4'h8, 32'hABAB_ABAB, 0, 0, 0,  1, 0, 0, 32'h0,  4'h0, 32'h0, 0);
        add(0, 0, 0, 0, 1, 32'h10, 0,                 1, 1, 1, 32'h10, 4'h8, 32'hABAB_ABAB, 1);
        add(0, 0, 0, 0, 0, 32'h10, 0,                 1, 0, 1, 32'h10, 4'h8, 32'hABAB_ABAB, 1);
        add(0, 0, 0, 0, 1, 32'h14, 0,                 1, 0, 1, 32'h10, 4'h8, 32'hABAB_ABAB, 1);
        add(0, 0, 0, 0, 1, 32'h10, 1,                 1, 1, 1, 32'h10, 4'h8, 32'hABAB_ABAB, 1);
        add(0, 0, 0, 0, 1, 32'h10, 0,                 1, 0, 0, 32'h0,  4'h0, 32'h0, 0);
        // full buffer: store with same-cycle ack is refused, taken next cycle
        add(1, 32'h40, 4'hF, 32'hB0, 0, 0, 0,         1, 0, 0, 32'h0,  4'h0, 32'h0,  0);
        add(1, 32'h44, 4'hF, 32'hB1, 0, 0, 0,         1, 0, 1, 32'h40, 4'hF, 32'hB0, 1);
        add(1, 32'h48, 4'hF, 32'hB2, 0, 0, 0,         1, 0, 1, 32'h40, 4'hF, 32'hB0, 2);
        add(1, 32'h4C, 4'hF, 32'hB3, 0, 0, 0,         1, 0, 1, 32'h40, 4'hF, 32'hB0, 3);
        add(1, 32'h50, 4'hF, 32'hB4, 1, 32'h4E, 1,    0, 1, 1, 32'h40, 4'hF, 32'hB0, 4);
        add(1, 32'h50, 4'hF, 32'hB4, 0, 0, 0,         1, 0, 1, 32'h44, 4'hF, 32'hB1, 3);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 1, 32'h44, 4'hF, 32'hB1, 4);
        add(0, 0, 0, 0, 0, 0, 1,                      0, 0, 1, 32'h44, 4'hF, 32'hB1, 4);
        add(0, 0, 0, 0, 0, 0, 1,                      1, 0, 1, 32'h48, 4'hF, 32'hB2, 3);
        add(0, 0, 0, 0, 0, 0, 1,                      1, 0, 1, 32'h4C, 4'hF, 32'hB3, 2);
        add(0, 0, 0, 0, 0, 0, 1,                      1, 0, 1, 32'h50, 4'hF, 32'hB4, 1);
        add(0, 0, 0, 0, 0, 0, 0,                      1, 0, 0, 32'h0,  4'h0, 32'h0,  0);
        // count=1 with simultaneous enqueue and ack
        add(1, 32'h60, 4'hF, 32'hC0, 0, 0, 0,         1, 0, 0, 32'h0,  4'h0, 32'h0,  0);
        add(1, 32'h64, 4'h3, 32'hC1, 0, 0, 1,         1, 0, 1, 32'h60, 4'hF, 32'hC0, 1);
        add(0, 0, 0, 0, 0, 0, 0,                      1, 0, 1, 32'h64, 4'h3, 32'hC1, 1);
        add(0, 0, 0, 0, 0, 0, 1,                      1, 0, 1, 32'h64, 4'h3, 32'hC1, 1);
        add(0, 0, 0, 0, 0, 0, 0,                      1, 0, 0, 32'h0,  4'h0, 32'h0,  0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            st_valid  = vq[i].sv;
            st_addr   = vq[i].sa;
            st_byteen = vq[i].sb;
            st_wdata  = vq[i].sd;
            ld_valid  = vq[i].lv;
            ld_addr   = vq[i].la;
            mem_ack   = vq[i].ack;
            #1;
            chk($sformatf("v%0d_st_ready", i), {31'h0, st_ready}, {31'h0, vq[i].e_ready});
            chk($sformatf("v%0d_ld_stall", i), {31'h0, ld_stall}, {31'h0, vq[i].e_stall});
            chk($sformatf("v%0d_mem_req", i), {31'h0, mem_req}, {31'h0, vq[i].e_req});
            chk($sformatf("v%0d_count", i), {29'h0, count}, {29'h0, vq[i].e_count});
            chk($sformatf("v%0d_empty", i), {31'h0, empty}, {31'h0, (vq[i].e_count == 3'd0)});
            if (vq[i].e_req) begin
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vq[i].e_addr);
                chk($sformatf("v%0d_mem_byteen", i), {28'h0, mem_byteen}, {28'h0, vq[i].e_be});
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vq[i].e_wdata);
            end
        end

        // ------- reset asserted mid-drain with mem_ack high -------
        @(negedge clk);
        drive_idle();
        st_valid = 1'b1; st_byteen = 4'hF; st_addr = 32'h70; st_wdata = 32'hD0;
        @(negedge clk);
        st_addr = 32'h74; st_wdata = 32'hD1;
        @(negedge clk);
        st_addr = 32'h78; st_wdata = 32'hD2;
        @(negedge clk);
        drive_idle();
        mem_ack = 1'b1;
        #1;
        chk("mid_count_before", {29'h0, count}, 32'd3);
        chk("mid_addr_before", mem_addr, 32'h70);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_req_async", {31'h0, mem_req}, 32'd0);
        chk("mid_count_async", {29'h0, count}, 32'd0);
        chk("mid_empty_async", {31'h0, empty}, 32'd1);
        chk("mid_ready_async", {31'h0, st_ready}, 32'd1);
        @(negedge clk);
        chk("mid_req_in_reset", {31'h0, mem_req}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst_req_%0d", k), {31'h0, mem_req}, 32'd0);
            chk($sformatf("post_rst_count_%0d", k), {29'h0, count}, 32'd0);
        end
        mem_ack = 1'b0;
        st_valid = 1'b1; st_byteen = 4'hF; st_addr = 32'h80; st_wdata = 32'hE0;
        @(negedge clk);
        drive_idle();
        #1;
        chk("post_rst_new_req", {31'h0, mem_req}, 32'd1);
        chk("post_rst_new_addr", mem_addr, 32'h80);
        chk("post_rst_new_wdata", mem_wdata, 32'hE0);
        chk("post_rst_new_count", {29'h0, count}, 32'd1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("final_empty", {31'h0, empty}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
